// File: rtl/i2c_pos_reader.sv
// I2C controller that polls the position/status responder: START, addr+R, 3 read bytes, STOP.
// Optional macro I2C_STRETCH_EN lets the responder stretch SCL during the high quarters.
//   state    | meaning
//   IDLE     | bus released, waiting for start
//   START    | START condition bit
//   ADDR     | shifting out {TARGET_ADDR, R}
//   ADDR_ACK | sampling responder address ACK
//   READ     | shifting in one data byte
//   MACK     | controller ACK (bytes 0,1) or NACK (byte 2)
//   STOP     | STOP condition bit
//   DONE     | one-cycle completion pulse, outputs refreshed
module i2c_pos_reader #(
    parameter logic [6:0]  TARGET_ADDR = 7'b1100100,
    parameter int unsigned CLK_DIV     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] x_pos,
    output logic [7:0] y_pos,
    output logic [7:0] status
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0] ADDR_BYTE = {TARGET_ADDR, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_READ, S_MACK, S_STOP, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       quarter_q, quarter_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [7:0]       sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic [7:0]       x_q, x_d, y_q, y_d, st_q, st_d;
    logic             ack_err_q, ack_err_d;
    logic             active, stall, tick, sample, bit_end;

    assign active = (state_q != S_IDLE) && (state_q != S_DONE);

`ifdef I2C_STRETCH_EN
    // SCL is released in q2; a low pad level there means the responder is stretching.
    assign stall = active && (quarter_q == 2'd2) && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign stall = 1'b0;
`endif

    assign tick    = active && !stall && (div_q == DIV_MAX);
    assign sample  = tick && (quarter_q == 2'd2);
    assign bit_end = tick && (quarter_q == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_START;
            S_START:    if (bit_end) state_d = S_ADDR;
            S_ADDR:     if (bit_end && (bit_q == 3'd7)) state_d = S_ADDR_ACK;
            S_ADDR_ACK: if (bit_end) state_d = ack_err_q ? S_STOP : S_READ;
            S_READ:     if (bit_end && (bit_q == 3'd7)) state_d = S_MACK;
            S_MACK:     if (bit_end) state_d = (byte_q == 2'd2) ? S_STOP : S_READ;
            S_STOP:     if (bit_end) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        div_d     = div_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        sh0_d     = sh0_q;
        sh1_d     = sh1_q;
        sh2_d     = sh2_q;
        ack_err_d = ack_err_q;
        x_d       = x_q;
        y_d       = y_q;
        st_d      = st_q;
        if (!active) begin
            div_d     = '0;
            quarter_d = '0;
            bit_d     = '0;
        end else if (stall || tick) begin
            div_d = '0;
            if (tick) quarter_d = quarter_q + 2'd1;
        end else begin
            div_d = div_q + 1'b1;
        end
        if (bit_end && ((state_q == S_ADDR) || (state_q == S_READ))) bit_d = bit_q + 3'd1;
        if ((state_q == S_IDLE) && start) begin
            byte_d    = '0;
            ack_err_d = 1'b0;
        end
        if (bit_end && (state_q == S_MACK)) byte_d = byte_q + 2'd1;
        if (sample && (state_q == S_ADDR_ACK) && sda_in) ack_err_d = 1'b1;
        if (sample && (state_q == S_READ)) begin
            case (byte_q)
                2'd0:    sh0_d = {sh0_q[6:0], sda_in};
                2'd1:    sh1_d = {sh1_q[6:0], sda_in};
                default: sh2_d = {sh2_q[6:0], sda_in};
            endcase
        end
        // Refresh on entry to DONE so the new values are visible with the done pulse.
        if ((state_q == S_STOP) && (state_d == S_DONE) && !ack_err_q) begin
            x_d  = sh0_q;
            y_d  = sh1_q;
            st_d = sh2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q     <= '0;
            quarter_q <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            sh0_q     <= '0;
            sh1_q     <= '0;
            sh2_q     <= '0;
            ack_err_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            st_q      <= '0;
        end else begin
            div_q     <= div_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            sh0_q     <= sh0_d;
            sh1_q     <= sh1_d;
            sh2_q     <= sh2_d;
            ack_err_q <= ack_err_d;
            x_q       <= x_d;
            y_q       <= y_d;
            st_q      <= st_d;
        end
    end

    always_comb begin
        sda_oe = 1'b0;
        scl_oe = 1'b0;
        case (state_q)
            S_START: begin
                sda_oe = quarter_q[1];
                scl_oe = (quarter_q == 2'd3);
            end
            S_ADDR: begin
                scl_oe = !quarter_q[1];
                sda_oe = !ADDR_BYTE[3'd7 - bit_q];
            end
            S_ADDR_ACK, S_READ: scl_oe = !quarter_q[1];
            S_MACK: begin
                scl_oe = !quarter_q[1];
                sda_oe = (byte_q != 2'd2);
            end
            S_STOP: begin
                scl_oe = (quarter_q == 2'd0);
                sda_oe = (quarter_q != 2'd3);
            end
            default: ;
        endcase
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign ack_err = ack_err_q;
    assign x_pos   = x_q;
    assign y_pos   = y_q;
    assign status  = st_q;
endmodule

// File: tb/tb_i2c_pos_reader.sv
// Directed bench for i2c_pos_reader with an open-drain bus and a simple responder model.
module tb_i2c_pos_reader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic sda_in, scl_in;
    logic sda_oe, scl_oe, busy, done, ack_err;
    logic [7:0] x_pos, y_pos, status;

    int total = 0;
    int bad = 0;

`ifdef I2C_STRETCH_EN
    localparam int STRETCH_EXTRA = 50;
`else
    localparam int STRETCH_EXTRA = 0;
`endif

    i2c_pos_reader #(.TARGET_ADDR(7'b1100100), .CLK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sda_in(sda_in), .scl_in(scl_in),
        .sda_oe(sda_oe), .scl_oe(scl_oe), .busy(busy), .done(done), .ack_err(ack_err),
        .x_pos(x_pos), .y_pos(y_pos), .status(status)
    );

    always #5 clk = ~clk;

    logic       ack_en = 1'b1;
    logic       stretch_en = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00, d2 = 8'h00;
    logic       started = 1'b0;
    int         fcount = 0, rises = 0, last_rises = 0, stop_cnt = 0, done_cnt = 0, stretch_cnt = 0;
    logic [7:0] addr_rx = 8'h00;
    logic       mack0 = 1'b0, mack1 = 1'b0, mack2 = 1'b1;
    logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_scl_oe = 1'b0;
    logic       resp_pull, scl_bus, sda_bus;

    // Bit b is being set up during the SCL low phase after the (b+1)-th fall since START.
    function automatic logic resp_drive(input int b, input logic [7:0] a0, input logic [7:0] a1,
                                        input logic [7:0] a2);
        if (b == 8) return 1'b1;
        if (b >= 9 && b <= 16) return !a0[16-b];
        if (b >= 18 && b <= 25) return !a1[25-b];
        if (b >= 27 && b <= 34) return !a2[34-b];
        return 1'b0;
    endfunction

    always_comb begin
        resp_pull = 1'b0;
        if (started && ack_en) resp_pull = resp_drive(fcount - 1, d0, d1, d2);
    end

    assign scl_bus = !scl_oe && (stretch_cnt == 0);
    assign sda_bus = !sda_oe && !resp_pull;
    assign scl_in  = scl_bus;
    assign sda_in  = sda_bus;

    always @(negedge clk) begin
        prev_scl    <= scl_bus;
        prev_sda    <= sda_bus;
        prev_scl_oe <= scl_oe;
        if (done) done_cnt <= done_cnt + 1;
        if (stretch_cnt != 0) stretch_cnt <= stretch_cnt - 1;
        if (!rst_n) begin
            started <= 1'b0;
        end else if (prev_scl && scl_bus && prev_sda && !sda_bus) begin
            started <= 1'b1;
            fcount  <= 0;
            rises   <= 0;
        end else if (prev_scl && scl_bus && !prev_sda && sda_bus) begin
            if (started) begin
                stop_cnt   <= stop_cnt + 1;
                last_rises <= rises;
            end
            started <= 1'b0;
        end else if (started) begin
            if (prev_scl && !scl_bus) fcount <= fcount + 1;
            if (!prev_scl && scl_bus) begin
                rises <= rises + 1;
                if (rises < 8) addr_rx <= {addr_rx[6:0], sda_bus};
                if (rises == 17) mack0 <= sda_oe;
                if (rises == 26) mack1 <= sda_oe;
                if (rises == 35) mack2 <= sda_oe;
            end
            if (stretch_en && prev_scl_oe && !scl_oe && fcount == 22) stretch_cnt <= 50;
        end
    end

    // Pulses start for one cycle and returns the done cycle index (start cycle + n), -1 on timeout.
    task automatic do_txn(input int poke_at, output int lat, output logic busy1, output logic err1);
        lat   = -1;
        busy1 = 1'b0;
        err1  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 3000; n++) begin
            if (n == 1) begin
                busy1 = busy;
                err1  = ack_err;
            end
            if (done) begin
                lat = n;
                break;
            end
            start = (n == poke_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL reset_sda_oe got=%b want=0", sda_oe); end
        total++; if (scl_oe !== 1'b0) begin bad++; $display("FAIL reset_scl_oe got=%b want=0", scl_oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL reset_ack_err got=%b want=0", ack_err); end
        total++; if (x_pos !== 8'h00) begin bad++; $display("FAIL reset_x got=%h want=00", x_pos); end
        total++; if (y_pos !== 8'h00) begin bad++; $display("FAIL reset_y got=%h want=00", y_pos); end
        total++; if (status !== 8'h00) begin bad++; $display("FAIL reset_status got=%h want=00", status); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_normal_read();
        int lat; logic b1, e1; int stops0;
        ack_en = 1'b1; d0 = 8'h12; d1 = 8'h34; d2 = 8'hC9;
        stops0 = stop_cnt;
        do_txn(0, lat, b1, e1);
        total++; if (lat !== 609) begin bad++; $display("FAIL read_latency got=%0d want=609", lat); end
        total++; if (b1 !== 1'b1) begin bad++; $display("FAIL read_busy_rise got=%b want=1", b1); end
        total++; if (x_pos !== 8'h12) begin bad++; $display("FAIL read_x got=%h want=12", x_pos); end
        total++; if (y_pos !== 8'h34) begin bad++; $display("FAIL read_y got=%h want=34", y_pos); end
        total++; if (status !== 8'hC9) begin bad++; $display("FAIL read_status got=%h want=c9", status); end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL read_ack_err got=%b want=0", ack_err); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b want=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_drop got=%b want=0", busy); end
        repeat (2) @(negedge clk);
        total++; if (stop_cnt !== stops0 + 1) begin bad++; $display("FAIL read_stop got=%0d want=%0d", stop_cnt, stops0 + 1); end
        // 36 bit clocks plus the SCL release that opens the STOP bit.
        total++; if (last_rises !== 37) begin bad++; $display("FAIL read_scl_rises got=%0d want=37", last_rises); end
        total++; if (addr_rx !== 8'hC9) begin bad++; $display("FAIL addr_byte got=%h want=c9", addr_rx); end
        total++; if (mack0 !== 1'b1) begin bad++; $display("FAIL mack_byte0 got=%b want=1", mack0); end
        total++; if (mack1 !== 1'b1) begin bad++; $display("FAIL mack_byte1 got=%b want=1", mack1); end
        total++; if (mack2 !== 1'b0) begin bad++; $display("FAIL mack_byte2 got=%b want=0", mack2); end
    endtask

    task automatic test_nack();
        int lat; logic b1, e1; int stops0;
        ack_en = 1'b0;
        stops0 = stop_cnt;
        do_txn(0, lat, b1, e1);
        total++; if (lat !== 177) begin bad++; $display("FAIL nack_latency got=%0d want=177", lat); end
        total++; if (ack_err !== 1'b1) begin bad++; $display("FAIL nack_ack_err got=%b want=1", ack_err); end
        total++; if (x_pos !== 8'h12) begin bad++; $display("FAIL nack_keep_x got=%h want=12", x_pos); end
        total++; if (y_pos !== 8'h34) begin bad++; $display("FAIL nack_keep_y got=%h want=34", y_pos); end
        total++; if (status !== 8'hC9) begin bad++; $display("FAIL nack_keep_status got=%h want=c9", status); end
        repeat (3) @(negedge clk);
        total++; if (stop_cnt !== stops0 + 1) begin bad++; $display("FAIL nack_stop got=%0d want=%0d", stop_cnt, stops0 + 1); end
        total++; if (last_rises !== 10) begin bad++; $display("FAIL nack_scl_rises got=%0d want=10", last_rises); end
        total++; if (ack_err !== 1'b1) begin bad++; $display("FAIL nack_sticky got=%b want=1", ack_err); end
    endtask

    task automatic test_ignored_start();
        int lat; logic b1, e1; int dc0;
        ack_en = 1'b1; d0 = 8'hA5; d1 = 8'h5A; d2 = 8'h0F;
        dc0 = done_cnt;
        do_txn(100, lat, b1, e1);
        total++; if (e1 !== 1'b0) begin bad++; $display("FAIL ack_err_clear got=%b want=0", e1); end
        total++; if (lat !== 609) begin bad++; $display("FAIL ignore_latency got=%0d want=609", lat); end
        repeat (20) @(negedge clk);
        total++; if (done_cnt - dc0 !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", done_cnt - dc0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_not_queued got=%b want=0", busy); end
        total++; if (x_pos !== 8'hA5) begin bad++; $display("FAIL ignore_x got=%h want=a5", x_pos); end
        total++; if (y_pos !== 8'h5A) begin bad++; $display("FAIL ignore_y got=%h want=5a", y_pos); end
        total++; if (status !== 8'h0F) begin bad++; $display("FAIL ignore_status got=%h want=0f", status); end
        d0 = 8'h3C; d1 = 8'hC3; d2 = 8'h81;
        do_txn(0, lat, b1, e1);
        total++; if (b1 !== 1'b1) begin bad++; $display("FAIL back_to_back_busy got=%b want=1", b1); end
        total++; if (lat !== 609) begin bad++; $display("FAIL back_to_back_latency got=%0d want=609", lat); end
        total++; if ({x_pos, y_pos, status} !== 24'h3CC381) begin bad++; $display("FAIL back_to_back_data got=%h want=3cc381", {x_pos, y_pos, status}); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat; logic b1, e1;
        ack_en = 1'b1; d0 = 8'h12; d1 = 8'h34; d2 = 8'hC9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (199) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL mid_rst_sda_oe got=%b want=0", sda_oe); end
        total++; if (scl_oe !== 1'b0) begin bad++; $display("FAIL mid_rst_scl_oe got=%b want=0", scl_oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
        total++; if ({x_pos, y_pos, status} !== 24'h0) begin bad++; $display("FAIL mid_rst_data got=%h want=000000", {x_pos, y_pos, status}); end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL mid_rst_ack_err got=%b want=0", ack_err); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        total++; if ({sda_oe, scl_oe, busy} !== 3'b000) begin bad++; $display("FAIL mid_rst_idle got=%b want=000", {sda_oe, scl_oe, busy}); end
        do_txn(0, lat, b1, e1);
        total++; if (lat !== 609) begin bad++; $display("FAIL post_rst_latency got=%0d want=609", lat); end
        total++; if ({x_pos, y_pos, status} !== 24'h1234C9) begin bad++; $display("FAIL post_rst_data got=%h want=1234c9", {x_pos, y_pos, status}); end
        @(negedge clk);
    endtask

    task automatic test_stretch();
        int lat; logic b1, e1;
        ack_en = 1'b1; d0 = 8'h6E; d1 = 8'h91; d2 = 8'h27;
        stretch_en = 1'b1;
        do_txn(0, lat, b1, e1);
        stretch_en = 1'b0;
        total++; if (lat !== 609 + STRETCH_EXTRA) begin bad++; $display("FAIL stretch_latency got=%0d want=%0d", lat, 609 + STRETCH_EXTRA); end
`ifdef I2C_STRETCH_EN
        total++; if ({x_pos, y_pos, status} !== 24'h6E9127) begin bad++; $display("FAIL stretch_data got=%h want=6e9127", {x_pos, y_pos, status}); end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL stretch_ack_err got=%b want=0", ack_err); end
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_normal_read();
        test_nack();
        test_ignored_start();
        test_reset_mid();
        test_stretch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
